fetch_stage: RTL

- First stage of the 6502 CPU pipeline in the NES core. It boots by reading the reset vector, then streams one instruction byte per cycle from program memory to the decode stage.
- Each byte is tagged with its 16-bit address and packed as f_to_d_reg = {pc[15:0], byte[7:0]}.
- It supports back-pressure from decode (stall) and a PC redirect from execute (branch/jump) that flushes in-flight bytes.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch for the 6502 pipeline: boots from the reset vector, then streams one
// address-tagged byte per cycle to decode with a 1-entry skid buffer and redirect flush.
module fetch_stage #(
  parameter logic [15:0] RESET_VECTOR     = 16'hFFFC,
  parameter bit          BOOT_FROM_VECTOR = 1'b1,
  parameter logic [15:0] RESET_PC         = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [23:0] f_to_d_reg,
  output logic        f_to_d_valid
);

  typedef enum logic [1:0] {StVecLo, StVecHi, StVecWait, StRun} state_e;

  localparam state_e      StBoot = BOOT_FROM_VECTOR ? StVecLo : StRun;
  localparam logic [15:0] PcBoot = BOOT_FROM_VECTOR ? 16'h0000 : RESET_PC;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic [23:0] skid_q, skid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [23:0] f_reg_q, f_reg_d;
  logic        f_valid_q, f_valid_d;
  logic        rd_en;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    vec_lo_d      = vec_lo_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
    f_reg_d       = f_reg_q;
    f_valid_d     = f_valid_q;
    mem_addr      = pc_q;
    rd_en         = 1'b0;
    unique case (state_q)
      StVecLo: begin
        mem_addr = RESET_VECTOR;
        rd_en    = 1'b1;
        state_d  = StVecHi;
      end
      StVecHi: begin
        mem_addr = RESET_VECTOR + 16'd1;
        rd_en    = 1'b1;
        vec_lo_d = mem_rdata;
        state_d  = StVecWait;
      end
      StVecWait: begin
        pc_d    = {mem_rdata, vec_lo_q};
        state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          // Flush everything in flight; the returning byte is simply not captured.
          pc_d         = redirect_pc;
          skid_valid_d = 1'b0;
          f_valid_d    = 1'b0;
        end else begin
          rd_en = !stall && !skid_valid_q;
          if (rd_en) begin
            pc_d          = pc_q + 16'd1;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
          end
          if (inflight_q) begin
            if (!stall) begin
              f_reg_d   = {inflight_pc_q, mem_rdata};
              f_valid_d = 1'b1;
            end else begin
              skid_d       = {inflight_pc_q, mem_rdata};
              skid_valid_d = 1'b1;
            end
          end else if (!stall) begin
            if (skid_valid_q) begin
              f_reg_d      = skid_q;
              f_valid_d    = 1'b1;
              skid_valid_d = 1'b0;
            end else begin
              f_valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StVecLo;
    endcase
  end

  // No read strobe may escape while reset is held, even though VEC_LO wants one.
  assign mem_rd_en    = rd_en && rst_n;
  assign f_to_d_reg   = f_reg_q;
  assign f_to_d_valid = f_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= PcBoot;
      vec_lo_q      <= 8'h00;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      skid_q        <= 24'h000000;
      skid_valid_q  <= 1'b0;
      f_reg_q       <= 24'h000000;
      f_valid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      vec_lo_q      <= vec_lo_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      f_reg_q       <= f_reg_d;
      f_valid_q     <= f_valid_d;
    end
  end

endmodule
